// File: rtl/bit_reducer_accumulator_if.sv
// Word-stream and result handshake bundle for bit_reducer_accumulator.
// Optional frame-end marker present when BIT_REDUCER_ACCUMULATOR_LAST_EN is defined.
interface bit_reducer_accumulator_if #(
   parameter int unsigned WORD_WIDTH = 8
);
   logic [2:0]            operation;
   logic                  in_valid;
   logic                  in_ready;
   logic [WORD_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_bit;
   logic                  out_error;
`ifdef BIT_REDUCER_ACCUMULATOR_LAST_EN
   logic                  in_last;

   // Producer/consumer side driving words and accepting results
   modport master (
      output operation, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_bit, out_error
   );

   // Reducer side
   modport slave (
      input  operation, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_bit, out_error
   );
`else
   // Producer/consumer side driving words and accepting results
   modport master (
      output operation, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_bit, out_error
   );

   // Reducer side
   modport slave (
      input  operation, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_bit, out_error
   );
`endif
endinterface

// File: rtl/bit_reducer_accumulator.sv
// Streaming Boolean bit reducer: folds a frame of WORDS_PER_FRAME words into
// one result bit using a run-time selected chained operation.
// Optional feature macro: BIT_REDUCER_ACCUMULATOR_LAST_EN (adds in_last early
// frame termination).
module bit_reducer_accumulator #(
   parameter int unsigned WORD_WIDTH      = 8,
   parameter int unsigned WORDS_PER_FRAME = 4
) (
   input  logic                    clock,
   input  logic                    clear,
   bit_reducer_accumulator_if.slave bus
);

   localparam int unsigned CNT_W    = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
   localparam int unsigned LAST_IDX = WORDS_PER_FRAME - 1;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_NAND = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;

   typedef enum logic {
      ST_ACCUMULATE = 1'b0,
      ST_OUTPUT     = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 acc_q, acc_d;
   logic [2:0]           op_q, op_d;
   logic                 err_q, err_d;
   logic                 out_bit_q, out_bit_d;
   logic                 out_error_q, out_error_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;

   logic                 first_word;
   logic [2:0]           fold_op;
   logic                 fold_res;
   logic                 frame_err;
   logic                 last_word;

   // One chained step; illegal codes behave as AND
   function automatic logic fold_step(input logic a, input logic b, input logic [2:0] op);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_NAND: r = ~(a & b);
         OP_OR:   r = a | b;
         OP_NOR:  r = ~(a | b);
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         default: r = a & b;
      endcase
      return r;
   endfunction

   // Fold a whole word; the first word of a frame seeds from its own bit 0
   function automatic logic fold_word(input logic acc_in, input logic [WORD_WIDTH-1:0] word,
                                      input logic seed, input logic [2:0] op);
      logic a;
      a = seed ? word[0] : fold_step(acc_in, word[0], op);
      for (int unsigned i = 1; i < WORD_WIDTH; i++) begin
         a = fold_step(a, word[i], op);
      end
      return a;
   endfunction

   // Operation is captured on the first word and held for the rest of the frame
   always_comb begin
      first_word = (count_q == CNT_W'(0));
      fold_op    = first_word ? bus.operation : op_q;
      frame_err  = first_word ? (bus.operation > OP_XNOR) : err_q;
      fold_res   = fold_word(acc_q, bus.in_data, first_word, fold_op);
`ifdef BIT_REDUCER_ACCUMULATOR_LAST_EN
      last_word  = (count_q == CNT_W'(LAST_IDX)) || bus.in_last;
`else
      last_word  = (count_q == CNT_W'(LAST_IDX));
`endif
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_d       = acc_q;
      op_d        = op_q;
      err_d       = err_q;
      out_bit_d   = out_bit_q;
      out_error_d = out_error_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_ACCUMULATE: begin
            if (bus.in_valid && in_ready_q) begin
               acc_d   = fold_res;
               op_d    = fold_op;
               err_d   = frame_err;
               count_d = count_q + CNT_W'(1);
               if (last_word) begin
                  out_bit_d   = fold_res;
                  out_error_d = frame_err;
                  count_d     = CNT_W'(0);
                  state_d     = ST_OUTPUT;
                  in_ready_d  = 1'b0;
                  out_valid_d = 1'b1;
               end
            end
         end
         ST_OUTPUT: begin
            if (bus.out_ready) begin
               state_d     = ST_ACCUMULATE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_ACCUMULATE;
            count_d     = CNT_W'(0);
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // FSM state and handshake flags
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q     <= ST_ACCUMULATE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Frame datapath and result registers
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         count_q     <= CNT_W'(0);
         acc_q       <= 1'b0;
         op_q        <= OP_AND;
         err_q       <= 1'b0;
         out_bit_q   <= 1'b0;
         out_error_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         acc_q       <= acc_d;
         op_q        <= op_d;
         err_q       <= err_d;
         out_bit_q   <= out_bit_d;
         out_error_q <= out_error_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_bit   = out_bit_q;
   assign bus.out_error = out_error_q;

endmodule

// File: tb/tb_bit_reducer_accumulator.sv
// Self-checking bench for bit_reducer_accumulator (WORD_WIDTH=4, WORDS_PER_FRAME=2).
module tb_bit_reducer_accumulator;

   localparam int unsigned W = 4;

   logic clock = 1'b0;
   logic clear = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   bit_reducer_accumulator_if #(.WORD_WIDTH(W)) bus ();

   bit_reducer_accumulator #(.WORD_WIDTH(W), .WORDS_PER_FRAME(2)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Reference: list all frame bits in order, seed with the first, chain the rest
   function automatic logic ref_fold(input int op, input logic [W-1:0] w0, input logic [W-1:0] w1,
                                     input int nwords);
      logic bits[$];
      logic acc;
      for (int i = 0; i < int'(W); i++) bits.push_back(w0[i]);
      if (nwords > 1)
         for (int i = 0; i < int'(W); i++) bits.push_back(w1[i]);
      acc = bits[0];
      for (int i = 1; i < bits.size(); i++) begin
         case (op)
            1:       acc = !(acc && bits[i]);
            2:       acc = acc || bits[i];
            3:       acc = !(acc || bits[i]);
            4:       acc = (acc != bits[i]);
            5:       acc = (acc == bits[i]);
            default: acc = acc && bits[i];
         endcase
      end
      return acc;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one word at a negedge, wait (bounded) for acceptance, return at the next negedge
   task automatic send_word(input logic [2:0] op, input logic [W-1:0] d, input logic last);
      int n = 0;
      bus.operation = op;
      bus.in_data   = d;
      bus.in_valid  = 1'b1;
`ifdef BIT_REDUCER_ACCUMULATOR_LAST_EN
      bus.in_last   = last;
`endif
      while (!bus.in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("word_accept", 32'(bus.in_ready), 32'd1);
      @(negedge clock);
      bus.in_valid = 1'b0;
`ifdef BIT_REDUCER_ACCUMULATOR_LAST_EN
      bus.in_last  = 1'b0;
`endif
      if (last) begin end
   endtask

   // Result must be present right after the last word; hold it for 'hold' cycles, then accept
   task automatic take_result(input string tag, input logic exp_bit, input logic exp_err, input int hold);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_bit"},   32'(bus.out_bit),   32'(exp_bit));
      check({tag, "_err"},   32'(bus.out_error), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         bus.in_valid  = 1'b1;
         bus.in_data   = W'($urandom);
         bus.operation = 3'($urandom);
         @(negedge clock);
         check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, "_hold_bit"},   32'(bus.out_bit),   32'(exp_bit));
         check({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
      check({tag, "_drop"},  32'(bus.out_valid), 32'd0);
      check({tag, "_ready"}, 32'(bus.in_ready),  32'd1);
   endtask

   task automatic frame(input string tag, input logic [2:0] op0, input logic [2:0] op1,
                        input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input logic exp_bit, input logic exp_err, input int hold);
      send_word(op0, w0, 1'b0);
      send_word(op1, w1, 1'b0);
      take_result(tag, exp_bit, exp_err, hold);
   endtask

   initial begin
      logic [2:0]   r_op0, r_op1;
      logic [W-1:0] r_w0, r_w1;
      int           gap;

      bus.operation = 3'd0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
`ifdef BIT_REDUCER_ACCUMULATOR_LAST_EN
      bus.in_last   = 1'b0;
`endif
      @(negedge clock);
      @(negedge clock);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_bit",   32'(bus.out_bit),   32'd0);
      check("rst_out_error", 32'(bus.out_error), 32'd0);
      clear = 1'b0;
      @(negedge clock);

      // Directed cases with hand-derived expectations
      frame("xor_parity", 3'd4, 3'd4, 4'h1, 4'h3, 1'b1, 1'b0, 0);
      frame("and_ones",   3'd0, 3'd0, 4'hF, 4'hF, 1'b1, 1'b0, 0);
      frame("and_zero",   3'd0, 3'd0, 4'hF, 4'h7, 1'b0, 1'b0, 0);
      frame("nand_chain", 3'd1, 3'd1, 4'hF, 4'hB, 1'b0, 1'b0, 0);
      frame("xnor_zero",  3'd5, 3'd5, 4'h0, 4'h0, 1'b1, 1'b0, 0);
      frame("backpress",  3'd2, 3'd2, 4'h0, 4'h4, 1'b1, 1'b0, 5);
      frame("illegal",    3'd6, 3'd2, 4'hF, 4'hF, 1'b1, 1'b1, 0);
      frame("illegal7",   3'd7, 3'd7, 4'hF, 4'hE, 1'b0, 1'b1, 1);
      frame("op_held",    3'd0, 3'd2, 4'hF, 4'h1, 1'b0, 1'b0, 0);

      // Clear mid-frame discards the partial frame
      send_word(3'd2, 4'h0, 1'b0);
      clear = 1'b1;
      #1;
      check("clr_mid_ready", 32'(bus.in_ready),  32'd1);
      check("clr_mid_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      frame("after_clear", 3'd2, 3'd2, 4'h0, 4'h1, 1'b1, 1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("no_extra", 32'(bus.out_valid), 32'd0);
      end

      // Clear while a result is pending drops it
      send_word(3'd6, 4'hF, 1'b0);
      send_word(3'd6, 4'hF, 1'b0);
      check("pend_valid", 32'(bus.out_valid), 32'd1);
      clear = 1'b1;
      #1;
      check("clr_out_valid", 32'(bus.out_valid), 32'd0);
      check("clr_out_bit",   32'(bus.out_bit),   32'd0);
      check("clr_out_error", 32'(bus.out_error), 32'd0);
      check("clr_in_ready",  32'(bus.in_ready),  32'd1);
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);

`ifdef BIT_REDUCER_ACCUMULATOR_LAST_EN
      // Early frame end, then a full frame starting from count 0
      send_word(3'd4, 4'h7, 1'b1);
      take_result("last_early", 1'b1, 1'b0, 0);
      frame("after_last", 3'd4, 3'd4, 4'h1, 4'h3, 1'b1, 1'b0, 0);
      send_word(3'd0, 4'hF, 1'b0);
      send_word(3'd0, 4'hF, 1'b1);
      take_result("last_on_limit", 1'b1, 1'b0, 0);
`endif

      // Randomized frames with gaps, mid-frame op changes and backpressure
      for (int f = 0; f < 40; f++) begin
         r_op0 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         r_op1 = 3'($urandom);
         r_w0  = W'($urandom);
         r_w1  = W'($urandom);
         send_word(r_op0, r_w0, 1'b0);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            bus.in_data   = W'($urandom);
            bus.operation = 3'($urandom);
            @(negedge clock);
         end
         send_word(r_op1, r_w1, 1'b0);
         take_result("rand", ref_fold(int'(r_op0), r_w0, r_w1, 2), (r_op0 > 3'd5),
                     $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
